// File: rtl/mux_f_cfg_pkg.sv
// Shared definitions for the mux-slice configuration loader: state encoding,
// counter sizing and the derived configuration width.
package mux_f_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        COMMIT = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } cfg_state_t;

    function automatic int total_bits(input int mux_level, input int num_slices);
        return mux_level * num_slices;
    endfunction

    // Room for TOTAL_BITS data bits plus an optional parity bit.
    function automatic int cnt_width(input int total);
        return $clog2(total + 2);
    endfunction

endpackage

// File: rtl/mux_f_cfg_shreg.sv
// Shadow shift register for the config loader; with MUX_F_CFG_PARITY_EN defined it
// also keeps a running XOR of every accepted bit.
module mux_f_cfg_shreg #(
    parameter int WIDTH = 12
) (
    input  logic             cclk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
`ifdef MUX_F_CFG_PARITY_EN
    input  logic             acc_en,
    output logic             parity,
`endif
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    // New bits enter at the LSB, so the first bit of a load ends up at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign data_next[gi] = bit_in;
            end else begin : g_upper
                assign data_next[gi] = data_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (clr) begin
            data_reg <= '0;
        end else if (shift_en) begin
            data_reg <= data_next;
        end
    end

    assign data = data_reg;

`ifdef MUX_F_CFG_PARITY_EN
    logic parity_reg;

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (clr) begin
            parity_reg <= 1'b0;
        end else if (acc_en) begin
            parity_reg <= parity_reg ^ bit_in;
        end
    end

    assign parity = parity_reg;
`endif

endmodule

// File: rtl/mux_f_cfg_loader.sv
// Serial configuration loader for a column of F7/F8 mux slices: assembles a bitstream
// and commits it to all slices with a single cen pulse. Define MUX_F_CFG_PARITY_EN for even-parity checking.
module mux_f_cfg_loader
    import mux_f_cfg_pkg::*;
#(
    parameter int MUX_LEVEL  = 3,
    parameter int NUM_SLICES = 4,
    parameter int TOTAL_BITS = total_bits(MUX_LEVEL, NUM_SLICES)
) (
    input  logic                  cclk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_bit,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  cen,
    output logic [TOTAL_BITS-1:0] config_out,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);

    localparam int CW = cnt_width(TOTAL_BITS);
`ifdef MUX_F_CFG_PARITY_EN
    localparam int LOAD_BITS = TOTAL_BITS + 1;
`else
    localparam int LOAD_BITS = TOTAL_BITS;
`endif

    cfg_state_t            state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [TOTAL_BITS-1:0] config_out_reg;
    logic                  cen_reg;
    logic                  done_reg;
    logic [TOTAL_BITS-1:0] shadow;
    logic                  accept;
    logic                  last_bit;
    logic                  shreg_clr;

    assign cfg_ready = (state_reg == LOAD) && !cfg_start;
    assign accept    = cfg_valid && cfg_ready;
    assign last_bit  = accept && (cnt_reg == CW'(LOAD_BITS - 1));
    // A start during COMMIT is ignored, so it must not wipe the shadow either.
    assign shreg_clr = cfg_start && (state_reg != COMMIT);

`ifdef MUX_F_CFG_PARITY_EN
    logic parity;
    logic parity_ok;
    logic err_reg;

    assign parity_ok = !(parity ^ cfg_bit);

    // The trailing parity bit is folded into the accumulator but never shifted into the shadow.
    mux_f_cfg_shreg #(.WIDTH(TOTAL_BITS)) u_shreg (
        .cclk     (cclk),
        .rst_n    (rst_n),
        .clr      (shreg_clr),
        .shift_en (accept && !last_bit),
        .bit_in   (cfg_bit),
        .acc_en   (accept),
        .parity   (parity),
        .data     (shadow)
    );
`else
    mux_f_cfg_shreg #(.WIDTH(TOTAL_BITS)) u_shreg (
        .cclk     (cclk),
        .rst_n    (rst_n),
        .clr      (shreg_clr),
        .shift_en (accept),
        .bit_in   (cfg_bit),
        .data     (shadow)
    );
`endif

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            config_out_reg <= '0;
            cen_reg        <= 1'b0;
            done_reg       <= 1'b0;
`ifdef MUX_F_CFG_PARITY_EN
            err_reg        <= 1'b0;
`endif
        end else begin
            cen_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    if (cfg_start) begin
                        cnt_reg <= '0;
                    end else if (last_bit) begin
`ifdef MUX_F_CFG_PARITY_EN
                        if (parity_ok) begin
                            state_reg      <= COMMIT;
                            cen_reg        <= 1'b1;
                            config_out_reg <= shadow;
                        end else begin
                            state_reg <= ERR;
                            err_reg   <= 1'b1;
                        end
`else
                        // Load the output with the final bit included so cen and data align.
                        state_reg      <= COMMIT;
                        cen_reg        <= 1'b1;
                        config_out_reg <= {shadow[TOTAL_BITS-2:0], cfg_bit};
`endif
                    end else if (accept) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                COMMIT: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                default: begin
                    if (cfg_start) begin
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                        done_reg  <= 1'b0;
`ifdef MUX_F_CFG_PARITY_EN
                        err_reg   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign cen        = cen_reg;
    assign config_out = config_out_reg;
    assign cfg_busy   = (state_reg == LOAD) || (state_reg == COMMIT);
    assign cfg_done   = done_reg;
`ifdef MUX_F_CFG_PARITY_EN
    assign cfg_err    = err_reg;
`else
    assign cfg_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_f_cfg_loader.sv
// Bench for mux_f_cfg_loader (MUX_LEVEL=2, NUM_SLICES=2): stream-level reference model
// checked every cycle, plus directed literal expectations. Honours MUX_F_CFG_PARITY_EN.
module tb_mux_f_cfg_loader;

    localparam int TB_BITS = 4;
`ifdef MUX_F_CFG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int STREAM = TB_BITS + PAR;

    logic               cclk;
    logic               rst_n;
    logic               cfg_start;
    logic               cfg_bit;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cen;
    logic [TB_BITS-1:0] config_out;
    logic               cfg_busy;
    logic               cfg_done;
    logic               cfg_err;

    mux_f_cfg_loader #(.MUX_LEVEL(2), .NUM_SLICES(2)) dut (
        .cclk       (cclk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cen        (cen),
        .config_out (config_out),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    always #5 cclk = ~cclk;

    int n_checks = 0;
    int n_pass   = 0;
    int cen_cnt  = 0;
    logic [TB_BITS-1:0] cen_val = '0;
    bit run = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: tracks the accepted-bit stream and what a committed word looks like.
    bit                 m_loading = 1'b0;
    bit                 m_q[$];
    logic               m_cen  = 1'b0;
    logic               m_done = 1'b0;
    logic               m_err  = 1'b0;
    logic               m_busy = 1'b0;
    logic [TB_BITS-1:0] m_out  = '0;

    initial forever begin
        @(posedge cclk or negedge rst_n);
        if (!rst_n) begin
            m_loading = 1'b0; m_q.delete();
            m_cen = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_out = '0;
        end else begin
            bit was_cen;
            was_cen = m_cen;
            m_cen   = 1'b0;
            if (was_cen) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end else if (cfg_start) begin
                m_loading = 1'b1; m_busy = 1'b1; m_q.delete();
                m_done = 1'b0; m_err = 1'b0;
            end else if (m_loading && cfg_valid) begin
                m_q.push_back(cfg_bit);
                if (m_q.size() == STREAM) begin
                    int v;
                    int ones;
                    v = 0; ones = 0;
                    for (int i = 0; i < STREAM; i++) ones += int'(m_q[i]);
                    for (int i = 0; i < TB_BITS; i++) v = v * 2 + int'(m_q[i]);
                    m_loading = 1'b0;
                    if (PAR == 0 || (ones % 2) == 0) begin
                        m_cen = 1'b1;
                        m_out = TB_BITS'(v);
                    end else begin
                        m_err  = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge cclk);
        if (run) begin
            chk("ready", cfg_ready, m_loading && !cfg_start);
            chk("cen", cen, m_cen);
            chk("config_out", config_out, m_out);
            chk("done", cfg_done, m_done);
            chk("busy", cfg_busy, m_busy);
            chk("err", cfg_err, m_err);
            if (cen === 1'b1) begin
                cen_cnt++;
                cen_val = config_out;
                $display("commit: config_out=%b at %0t", config_out, $time);
            end
        end
    end

    task automatic cyc(input logic s, input logic v, input logic b);
        cfg_start = s; cfg_valid = v; cfg_bit = b;
        @(posedge cclk); #1;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    endtask

    task automatic send_word(input logic [TB_BITS-1:0] w);
        logic p;
        p = ^w;
        for (int i = TB_BITS - 1; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
        if (PAR == 1) cyc(1'b0, 1'b1, p);
    endtask

    initial begin
        cclk = 1'b0; rst_n = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        repeat (2) @(posedge cclk);
        #1;
        chk("rst_config_out", config_out, 0);
        chk("rst_cen", cen, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_busy", cfg_busy, 0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);

        // Back-to-back 1,0,1,1
        cen_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0);
        send_word(4'b1011);
        chk("t1_cen_latency", cen, 1);
        chk("t1_cen_data", config_out, 4'b1011);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_done", cfg_done, 1);
        chk("t1_cen_drop", cen, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("t1_cen_count", cen_cnt, 1);
        chk("t1_cen_val", cen_val, 4'b1011);

        // Same stream with a 3-cycle valid gap
        cen_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("t2_ready_gap", cfg_ready, 1);
        end
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        if (PAR == 1) cyc(1'b0, 1'b1, 1'b1);
        chk("t2_cen_latency", cen, 1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("t2_cen_count", cen_cnt, 1);
        chk("t2_cen_val", cen_val, 4'b1011);

        // Restart mid-load
        cen_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t3_hold_a", config_out, 4'b1011);
        cyc(1'b1, 1'b0, 1'b0);
        chk("t3_hold_b", config_out, 4'b1011);
        send_word(4'b0010);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("t3_cen_count", cen_cnt, 1);
        chk("t3_cen_val", cen_val, 4'b0010);

        // Start has priority over a bit presented in the same cycle
        cen_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        #1;
        chk("t4_ready_on_start", cfg_ready, 0);
        @(posedge cclk); #1;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        send_word(4'b0001);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("t4_cen_count", cen_cnt, 1);
        chk("t4_cen_val", cen_val, 4'b0001);

        // Reset mid-load
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_config_out", config_out, 0);
        chk("t5_rst_cen", cen, 0);
        chk("t5_rst_busy", cfg_busy, 0);
        @(posedge cclk); #1;
        rst_n = 1'b1;
        cen_cnt = 0;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'(i % 2));
        chk("t5_no_cen", cen_cnt, 0);
        chk("t5_idle_busy", cfg_busy, 0);
        chk("t5_config_out", config_out, 0);

`ifdef MUX_F_CFG_PARITY_EN
        // Good parity commits, bad parity flags an error
        cen_cnt = 0;
        cyc(1'b1, 1'b0, 1'b0);
        send_word(4'b1011);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t6_good_val", config_out, 4'b1011);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("t6_err", cfg_err, 1);
        chk("t6_cen_count", cen_cnt, 1);
        chk("t6_hold", config_out, 4'b1011);
        chk("t6_done", cfg_done, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("t6_err_clear", cfg_err, 0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
`endif

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_f_cfg_loader.md
Name: mux_f_cfg_loader

Overview:
- Configuration sequencer for a column of F7/F8-style mux slices.
- Accepts a serial config bitstream with a valid/ready handshake and assembles it into a shadow register.
- After a complete load, presents the full per-slice config_in bus and pulses a single-cycle commit enable, so all slices update on the same cclk edge.
- Sits between the fabric config shift chain and the cen/config_in pins of NUM_SLICES mux slices.

Parameters:
- MUX_LEVEL, 3, config bits per slice; must match the slice's MUX_LEVEL.
- NUM_SLICES, 4, number of mux slices driven.
- TOTAL_BITS, NUM_SLICES*MUX_LEVEL, derived; do not override.

Ports:
- cclk  in  1  configuration clock; all state is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  begin (or restart) a load.
- cfg_bit  in  1  serial config data.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_ready  out  1  loader accepts a bit this cycle.
- cen  out  1  commit pulse to all slices.
- config_out  out  TOTAL_BITS  slice i uses config_out[i*MUX_LEVEL +: MUX_LEVEL].
- cfg_busy  out  1  high in LOAD or COMMIT.
- cfg_done  out  1  high from the cycle after commit until the next cfg_start.
- cfg_err  out  1  parity error flag (see Optional Feature).

Behaviour:
- States: IDLE, LOAD, COMMIT, DONE, plus ERR when the optional feature is enabled.
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, shadow=0, config_out=0.
  - cen=0, cfg_done=0, cfg_err=0, cfg_busy=0.
  - No cen pulse is issued out of reset.
- IDLE, DONE or ERR with cfg_start=1: next state LOAD. Counter and shadow clear; cfg_done and cfg_err clear.
- LOAD:
  - cfg_ready = (state==LOAD) && !cfg_start. This is combinational; start has priority and a bit presented on a start cycle is dropped.
  - Accept a bit when cfg_valid && cfg_ready: shadow <= {shadow[TOTAL_BITS-2:0], cfg_bit}, counter++.
  - Bit order: the first accepted bit ends at config_out[TOTAL_BITS-1], the last at config_out[0].
  - cfg_valid low stalls with no state change; gaps of any length are legal.
  - cfg_start in LOAD restarts the load: counter=0, partial bits discarded, config_out unchanged.
  - On the cycle the final bit is accepted (counter==TOTAL_BITS-1 with a handshake), next state is COMMIT.
- COMMIT (exactly 1 cycle):
  - Registered cen=1 and config_out=shadow in the same cycle, so slices capture on the following edge.
  - cfg_start is ignored in this cycle.
  - Next state DONE.
- DONE: cfg_done=1, cen=0, config_out held stable until the next successful commit.
- Latency: final accepted bit at edge N; cen high during cycle N+1; cfg_done high from N+2.
- config_out changes only in COMMIT. cen is never high for more than one consecutive cycle.
- Counter width is $clog2(TOTAL_BITS+2); it never wraps because LOAD exits at the terminal count.
- Reset mid-LOAD or mid-COMMIT: immediate return to reset values; a COMMIT interrupted by reset produces no partial cen.

Optional Feature:
- Macro: MUX_F_CFG_PARITY_EN.
- Enabled:
  - The stream carries TOTAL_BITS data bits followed by one even-parity bit, so LOAD accepts TOTAL_BITS+1 bits.
  - Match: COMMIT as normal.
  - Mismatch: go to ERR. cfg_err=1, no cen pulse, config_out unchanged, cfg_done=0. ERR exits only on cfg_start.
- Disabled: cfg_err tied 0, exactly TOTAL_BITS bits per load, no ERR state.

Decomposition:
- Shared package mux_f_cfg_pkg holds:
  - state encoding constants (IDLE=0, LOAD=1, COMMIT=2, DONE=3, ERR=4);
  - a clog2-based counter-width function;
  - the TOTAL_BITS derivation.
- One natural sub-module, mux_f_cfg_shreg: the shadow shift register with clear and shift-enable, plus a running parity accumulator when the macro is set.
- The FSM, counter and output registers stay in the top module.

Test Plan (MUX_LEVEL=2, NUM_SLICES=2, TOTAL_BITS=4):
- Reset, then start, then bits 1,0,1,1 back-to-back -> cen high for exactly one cycle, config_out=4'b1011 in that cycle, cfg_done=1 the cycle after.
- Same stream with cfg_valid low for 3 cycles between bits 2 and 3 -> cfg_ready stays high, result still 4'b1011, cen pulse occurs 1 cycle after the 4th handshake.
- After committing 4'b1011, start and send 1,1 then start again, then 0,0,1,0 -> single cen, config_out=4'b0010, and config_out held at 4'b1011 throughout the aborted load.
- Start asserted together with cfg_valid=1, cfg_bit=1 -> cfg_ready=0 that cycle and the bit is not counted; 4 further bits are required.
- rst_n pulsed low mid-LOAD after 2 bits -> config_out=0, cen=0, state IDLE; cfg_bit toggling afterwards without a start produces no cen.
- With MUX_F_CFG_PARITY_EN: stream 1,0,1,1,+parity 1 -> commits 4'b1011. Stream 1,0,1,1,+parity 0 -> cfg_err=1, no cen, config_out unchanged; next start clears cfg_err.
